cpu7_ifu_ibus_resp: RTL and testbench
=====================================

Name: cpu7_ifu_ibus_resp

Overview:
Responder end of the cpu7 instruction-fetch request/response protocol. It accepts fetch requests from the IFU and issues in-order reads to a simple pipelined instruction memory port. It returns one instruction per response and flags uncached regions. It generates ADEF fetch exceptions for misaligned addresses and discards in-flight responses when the IFU cancels.

Parameters:
DEPTH, 4, max outstanding accepted requests; power of 2, at least 2.
UC_BASE, 32'hbfc00000, base of the uncached address window.
UC_MASK, 32'hfff00000, mask: addr in window iff (addr & UC_MASK) == UC_BASE.
EXCC_ADEF, 6'h08, exccode returned for a misaligned fetch.

Ports:
clock  in  1  single clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  IFU fetch request
inst_addr  in  32  fetch address
inst_cancel  in  1  IFU flush; drop all in-flight responses
inst_addr_ok  out  1  request accepted this cycle
inst_valid_f  out  1  response valid
inst_rdata_f  out  `GRLEN  instruction word
inst_count  out  2  instructions in response (always 2'd1 when valid, else 0)
inst_uncache  out  1  response address was in the uncached window
inst_ex  out  1  response carries exception
inst_exccode  out  6  exception code (valid with inst_ex)
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned memory address
mem_gnt  in  1  memory accepted mem_req this cycle
mem_rvalid  in  1  memory read data valid (in order, latency at least 1 cycle)
mem_rdata  in  32  memory read data

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0, queue empty, state IDLE. Reset mid-transaction abandons outstanding memory reads. Memory must be reset together with this block.
- Metadata queue: DEPTH entries, each {ex, uncache, discard}. Pointers wrap modulo DEPTH. A full-flag bit distinguishes full from empty.
- Acceptance is combinational. inst_addr_ok = inst_req & ~inst_cancel & ~full & ~ex_pending & path_ok.
  - Aligned address (addr[1:0]==0): path_ok = mem_gnt. mem_req = inst_req & ~inst_cancel & ~full & ~ex_pending. mem_addr = {inst_addr[31:2],2'b00}.
  - Misaligned address: mem_req=0; path_ok = queue empty; entry pushed with ex=1.
- ex_pending: an ex entry is queued. While set, no request is accepted.
- Push occurs on inst_addr_ok. uncache = window match.
- Response register (1-cycle latency). The queue head pops when:
  - head.ex=1: next cycle, no memory data consumed;
  - head.ex=0 and mem_rvalid: data captured.
- Popped entry with discard=0: next cycle inst_valid_f=1 with rdata, uncache and ex from the entry, exccode=EXCC_ADEF if ex else 0, inst_count=1.
- Popped entry with discard=1: consumed silently, no response.
- mem_rvalid with an empty queue is a protocol error; simulation assertion.
- inst_cancel:
  - Sets discard on every queued entry.
  - Masks the response output that cycle: inst_valid_f = resp_q & ~inst_cancel.
  - No request is accepted that cycle.
  - An entry popping in the same cycle is treated as discarded.
- FSM (response side): IDLE (queue empty), WAIT_MEM (head ex=0), EXC (head ex=1, pops next cycle). Transitions follow the head entry after each push or pop.
- Simultaneous push and pop keeps the occupancy count unchanged, even when full (pop frees the slot first only if DEPTH-1 is occupied; full blocks acceptance regardless).
- Throughput: 1 request/cycle sustained while mem_gnt=1 and the queue is not full.

Decomposition:
- Shared package/header: EXCC_ADEF, uncached window constants, queue entry field layout.
- One natural sub-module, cpu7_ifu_ibus_fifo: a synchronous metadata FIFO. Interface: push/pop, full/empty, a broadcast "set all discard" input and head visibility.
- FSM and response register stay in the top module.

Test Plan:
- Back-to-back aligned reads at 0x1c000000, 0x1c000004, 0x1c000008, memory latency 2 -> three responses in order, data matches, inst_count=1, inst_uncache=0, one response per cycle after the first.
- Fetch 0xbfc00010 -> response has inst_uncache=1. Fetch 0x1c000002 -> mem_req stays 0, inst_ex=1, inst_exccode=6'h08, and no other request is accepted until that response appears.
- Issue 3 reads, pulse inst_cancel before any data, then read 0x1c000100 -> the three memory returns are swallowed; the only response carries data of 0x1c000100.
- Hold mem_rvalid=0, issue DEPTH=4 requests -> inst_addr_ok drops on the 5th. Return one datum -> acceptance resumes the cycle after the pop; pointers wrap correctly over 10 further requests.
- Hold mem_gnt=0 with inst_req=1 -> inst_addr_ok=0 and no push; mem_gnt=1 -> accepted the same cycle.
- Assert resetn low with 2 requests outstanding -> all outputs 0 asynchronously. After release, a first fetch returns correctly with no stale response.

Source files
------------

// File: rtl/cpu7_ifu_ibus_resp_pkg.sv
// Shared types and defaults for the cpu7 instruction-bus responder:
// exception code, uncached window, metadata queue entry and response FSM states.
package cpu7_ifu_ibus_resp_pkg;

   localparam int          GRLEN          = 32;
   localparam logic [5:0]  IBUS_EXCC_ADEF = 6'h08;
   localparam logic [31:0] IBUS_UC_BASE   = 32'hbfc00000;
   localparam logic [31:0] IBUS_UC_MASK   = 32'hfff00000;

   typedef struct packed {
      logic ex;
      logic uncache;
      logic discard;
   } q_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_EXC      = 2'd2
   } rsp_state_e;

   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/cpu7_ifu_ibus_resp_if.sv
// IFU fetch request/response and instruction-memory read port bundled together;
// slave is the responder block, master is whatever drives the IFU and memory side.
interface cpu7_ifu_ibus_resp_if;
   import cpu7_ifu_ibus_resp_pkg::*;

   logic             inst_req;
   logic [31:0]      inst_addr;
   logic             inst_cancel;
   logic             inst_addr_ok;
   logic             inst_valid_f;
   logic [GRLEN-1:0] inst_rdata_f;
   logic [1:0]       inst_count;
   logic             inst_uncache;
   logic             inst_ex;
   logic [5:0]       inst_exccode;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic             mem_gnt;
   logic             mem_rvalid;
   logic [31:0]      mem_rdata;

   modport slave (
      input  inst_req, inst_addr, inst_cancel, mem_gnt, mem_rvalid, mem_rdata,
      output inst_addr_ok, inst_valid_f, inst_rdata_f, inst_count, inst_uncache,
             inst_ex, inst_exccode, mem_req, mem_addr
   );

   modport master (
      output inst_req, inst_addr, inst_cancel, mem_gnt, mem_rvalid, mem_rdata,
      input  inst_addr_ok, inst_valid_f, inst_rdata_f, inst_count, inst_uncache,
             inst_ex, inst_exccode, mem_req, mem_addr
   );

endinterface

// File: rtl/cpu7_ifu_ibus_fifo.sv
// Metadata queue for accepted fetches; head visible combinationally, push/pop same cycle keeps occupancy.
// A full flag separates full from empty; set_discard marks every slot so in-flight returns are dropped.
module cpu7_ifu_ibus_fifo
   import cpu7_ifu_ibus_resp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clock,
   input  logic     resetn,
   input  logic     push,
   input  q_entry_t push_dat,
   input  logic     pop,
   input  logic     set_discard,
   output q_entry_t head,
   output logic     full,
   output logic     empty,
   output logic     one_left
);

   localparam int AW = $clog2(DEPTH);

   q_entry_t        slot [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            full_q;

   assign head     = slot[rptr];
   assign full     = full_q;
   assign empty    = (wptr == rptr) & ~full_q;
   assign one_left = ~full_q & ((wptr - rptr) == AW'(1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
         wptr   <= '0;
         rptr   <= '0;
         full_q <= 1'b0;
      end else begin
         // Broadcast first so a same-cycle push still lands with its own discard bit.
         if (set_discard) begin
            for (int i = 0; i < DEPTH; i++) slot[i].discard <= 1'b1;
         end
         if (push) slot[wptr] <= push_dat;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      full_q <= ((wptr + 1'b1) == rptr);
         else if (pop && !push) full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu7_ifu_ibus_resp.sv
// In-order fetch responder: combinational accept, one registered response per popped entry (1-cycle latency).
// Stalls acceptance on full queue, pending ADEF entry, cancel or missing mem_gnt.
module cpu7_ifu_ibus_resp
   import cpu7_ifu_ibus_resp_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] UC_BASE   = IBUS_UC_BASE,
   parameter logic [31:0] UC_MASK   = IBUS_UC_MASK,
   parameter logic [5:0]  EXCC_ADEF = IBUS_EXCC_ADEF
) (
   input  logic                    clock,
   input  logic                    resetn,
   cpu7_ifu_ibus_resp_if.slave     bus
);

   q_entry_t         head;
   q_entry_t         push_dat;
   logic             full, empty, one_left;
   logic             push, pop;
   logic             aligned, ex_pending, can_req;
   rsp_state_e       state_q, state_nx;
   logic             rsp_vld_q, rsp_uc_q, rsp_ex_q;
   logic [GRLEN-1:0] rsp_dat_q;
   logic             rsp_out;

   assign aligned    = (bus.inst_addr[1:0] == 2'b00);
   // An ADEF entry can only be queued alone, so it is always the head.
   assign ex_pending = ~empty & head.ex;
   assign can_req    = resetn & bus.inst_req & ~bus.inst_cancel & ~full & ~ex_pending;

   assign bus.mem_req      = can_req & aligned;
   assign bus.mem_addr     = resetn ? {bus.inst_addr[31:2], 2'b00} : 32'h0;
   assign push             = can_req & (aligned ? bus.mem_gnt : empty);
   assign bus.inst_addr_ok = push;

   always_comb begin
      push_dat         = '0;
      push_dat.ex      = ~aligned;
      push_dat.uncache = in_window(bus.inst_addr, UC_BASE, UC_MASK);
   end

   assign pop = (state_q == ST_EXC) | ((state_q == ST_WAIT_MEM) & bus.mem_rvalid);

   cpu7_ifu_ibus_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .resetn      (resetn),
      .push        (push),
      .push_dat    (push_dat),
      .pop         (pop),
      .set_discard (bus.inst_cancel),
      .head        (head),
      .full        (full),
      .empty       (empty),
      .one_left    (one_left)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_nx;
   end

   // Nothing can queue behind an ADEF entry, so the next head after a pop is always a memory read.
   always_comb begin
      state_nx = state_q;
      if (pop && !push)
         state_nx = one_left ? ST_IDLE : ST_WAIT_MEM;
      else if (push && !pop && empty)
         state_nx = push_dat.ex ? ST_EXC : ST_WAIT_MEM;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rsp_vld_q <= 1'b0;
         rsp_uc_q  <= 1'b0;
         rsp_ex_q  <= 1'b0;
         rsp_dat_q <= '0;
      end else begin
         rsp_vld_q <= pop & ~head.discard & ~bus.inst_cancel;
         if (pop) begin
            rsp_dat_q <= head.ex ? '0 : bus.mem_rdata;
            rsp_uc_q  <= head.uncache;
            rsp_ex_q  <= head.ex;
         end
      end
   end

   assign rsp_out          = rsp_vld_q & ~bus.inst_cancel;
   assign bus.inst_valid_f = rsp_out;
   assign bus.inst_rdata_f = rsp_out ? rsp_dat_q : '0;
   assign bus.inst_count   = {1'b0, rsp_out};
   assign bus.inst_uncache = rsp_out & rsp_uc_q;
   assign bus.inst_ex      = rsp_out & rsp_ex_q;
   assign bus.inst_exccode = (rsp_out & rsp_ex_q) ? EXCC_ADEF : 6'h00;

   no_orphan_rdata: assert property (@(posedge clock) disable iff (!resetn)
                                     !(bus.mem_rvalid && empty));

endmodule

// File: tb/tb_cpu7_ifu_ibus_resp.sv
// Directed bench for cpu7_ifu_ibus_resp: pipelined memory responder, response monitor, hand-computed expectations.
// Memory word at address a is a ^ 32'hdead0000.
module tb_cpu7_ifu_ibus_resp;
   import cpu7_ifu_ibus_resp_pkg::*;

   logic clock;
   logic resetn;

   cpu7_ifu_ibus_resp_if bus ();

   cpu7_ifu_ibus_resp #(.DEPTH(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   int          cyc          = 0;
   int          mem_lat      = 2;
   int          mem_limit    = 1 << 30;
   int          mem_returned = 0;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   initial begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      forever begin
         @(posedge clock);
         if (resetn && bus.mem_req && bus.mem_gnt) begin
            pend_addr.push_back(bus.mem_addr);
            pend_due.push_back(cyc + mem_lat);
         end
         cyc++;
         #1;
         if (!resetn) begin
            pend_addr.delete();
            pend_due.delete();
            bus.mem_rvalid = 1'b0;
         end else if (pend_addr.size() > 0 && cyc >= pend_due[0] && mem_returned < mem_limit) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = pend_addr.pop_front() ^ 32'hdead0000;
            void'(pend_due.pop_front());
            mem_returned++;
         end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
         end
      end
   end

   // ---------------- response monitor ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        uc;
      logic        ex;
      logic [5:0]  code;
      logic [1:0]  cnt;
      logic [31:0] cyc;
   } rsp_t;

   rsp_t rsp_q [$];

   initial begin
      forever begin
         rsp_t r;
         @(negedge clock);
         #2;
         if (bus.inst_valid_f === 1'b1) begin
            r.d    = bus.inst_rdata_f;
            r.uc   = bus.inst_uncache;
            r.ex   = bus.inst_ex;
            r.code = bus.inst_exccode;
            r.cnt  = bus.inst_count;
            r.cyc  = 32'(cyc);
            rsp_q.push_back(r);
         end
      end
   end

   function automatic rsp_t get_rsp(input int i);
      rsp_t r = '0;
      if (i < rsp_q.size()) r = rsp_q[i];
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic req, input logic [31:0] addr, input logic cancel);
      @(negedge clock);
      bus.inst_req    = req;
      bus.inst_addr   = addr;
      bus.inst_cancel = cancel;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'h0, 1'b0);
   endtask

   task automatic wait_rsp(input string tag, input int n, input int budget);
      int k = 0;
      while (rsp_q.size() < n && k < budget) begin
         idle(1);
         k++;
      end
      check_eq(tag, 32'(rsp_q.size() >= n), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base, t0, idx, k;
      resetn          = 1'b0;
      bus.inst_req    = 1'b1;
      bus.inst_addr   = 32'h1c000000;
      bus.inst_cancel = 1'b0;
      bus.mem_gnt     = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      check_eq("rst addr_ok", 32'(bus.inst_addr_ok), 32'd0);
      check_eq("rst mem_req", 32'(bus.mem_req),      32'd0);
      check_eq("rst valid",   32'(bus.inst_valid_f), 32'd0);
      check_eq("rst count",   32'(bus.inst_count),   32'd0);
      bus.inst_req = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      idle(2);

      // back-to-back aligned reads, latency 2
      base = rsp_q.size();
      mem_lat = 2;
      drive(1'b1, 32'h1c000000, 1'b0);
      t0 = cyc;
      check_eq("seq ok0",   32'(bus.inst_addr_ok), 32'd1);
      check_eq("seq addr0", bus.mem_addr,          32'h1c000000);
      drive(1'b1, 32'h1c000004, 1'b0);
      check_eq("seq ok1",   32'(bus.inst_addr_ok), 32'd1);
      drive(1'b1, 32'h1c000008, 1'b0);
      check_eq("seq ok2",   32'(bus.inst_addr_ok), 32'd1);
      idle(1);
      wait_rsp("seq timeout", base + 3, 20);
      check_eq("seq d0",    get_rsp(base).d,     32'hc2ad0000);
      check_eq("seq d1",    get_rsp(base + 1).d, 32'hc2ad0004);
      check_eq("seq d2",    get_rsp(base + 2).d, 32'hc2ad0008);
      check_eq("seq cnt",   32'(get_rsp(base).cnt), 32'd1);
      check_eq("seq uc",    32'(get_rsp(base).uc),  32'd0);
      check_eq("seq lat",   get_rsp(base).cyc - 32'(t0), 32'd3);
      check_eq("seq gap1",  get_rsp(base + 1).cyc - get_rsp(base).cyc,     32'd1);
      check_eq("seq gap2",  get_rsp(base + 2).cyc - get_rsp(base + 1).cyc, 32'd1);

      // uncached window
      base = rsp_q.size();
      drive(1'b1, 32'hbfc00010, 1'b0);
      check_eq("uc ok", 32'(bus.inst_addr_ok), 32'd1);
      idle(1);
      wait_rsp("uc timeout", base + 1, 20);
      check_eq("uc flag", 32'(get_rsp(base).uc), 32'd1);
      check_eq("uc data", get_rsp(base).d,       32'h616d0010);
      check_eq("uc ex",   32'(get_rsp(base).ex), 32'd0);

      // misaligned fetch -> ADEF, blocks the next request until its response
      base = rsp_q.size();
      drive(1'b1, 32'h1c000002, 1'b0);
      check_eq("adef mem_req", 32'(bus.mem_req),      32'd0);
      check_eq("adef ok",      32'(bus.inst_addr_ok), 32'd1);
      drive(1'b1, 32'h1c000004, 1'b0);
      check_eq("adef block ok",  32'(bus.inst_addr_ok), 32'd0);
      check_eq("adef block req", 32'(bus.mem_req),      32'd0);
      drive(1'b1, 32'h1c000004, 1'b0);
      check_eq("adef valid", 32'(bus.inst_valid_f), 32'd1);
      check_eq("adef ex",    32'(bus.inst_ex),      32'd1);
      check_eq("adef code",  32'(bus.inst_exccode), 32'h08);
      check_eq("adef cnt",   32'(bus.inst_count),   32'd1);
      check_eq("adef resume", 32'(bus.inst_addr_ok), 32'd1);
      idle(1);
      wait_rsp("adef timeout", base + 2, 20);
      check_eq("adef next d",  get_rsp(base + 1).d,       32'hc2ad0004);
      check_eq("adef next ex", 32'(get_rsp(base + 1).ex), 32'd0);

      // cancel swallows in-flight reads
      idle(3);
      base = rsp_q.size();
      mem_lat = 4;
      drive(1'b1, 32'h1c000010, 1'b0);
      drive(1'b1, 32'h1c000014, 1'b0);
      drive(1'b1, 32'h1c000018, 1'b0);
      drive(1'b1, 32'h1c000100, 1'b1);
      check_eq("cancel ok",  32'(bus.inst_addr_ok), 32'd0);
      check_eq("cancel req", 32'(bus.mem_req),      32'd0);
      drive(1'b1, 32'h1c000100, 1'b0);
      check_eq("post cancel ok", 32'(bus.inst_addr_ok), 32'd1);
      idle(20);
      check_eq("cancel count", 32'(rsp_q.size() - base), 32'd1);
      check_eq("cancel data",  get_rsp(base).d,          32'hc2ad0100);

      // queue full, then wrap-around
      base = rsp_q.size();
      mem_lat = 2;
      mem_limit = mem_returned;
      idx = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1c000200 + 32'(4 * i), 1'b0);
         if (bus.inst_addr_ok === 1'b1) idx++;
      end
      check_eq("fill accepted", 32'(idx), 32'd4);
      drive(1'b1, 32'h1c000210, 1'b0);
      check_eq("full ok", 32'(bus.inst_addr_ok), 32'd0);
      mem_limit = mem_returned + 1;
      drive(1'b1, 32'h1c000210, 1'b0);
      check_eq("full hold ok", 32'(bus.inst_addr_ok), 32'd0);
      drive(1'b1, 32'h1c000210, 1'b0);
      check_eq("full resume ok", 32'(bus.inst_addr_ok), 32'd1);
      idx = 5;
      mem_limit = 1 << 30;
      k = 0;
      while (idx < 14 && k < 80) begin
         drive(1'b1, 32'h1c000200 + 32'(4 * idx), 1'b0);
         if (bus.inst_addr_ok === 1'b1) idx++;
         k++;
      end
      check_eq("wrap accepted", 32'(idx), 32'd14);
      idle(1);
      wait_rsp("wrap timeout", base + 14, 80);
      for (int i = 0; i < 14; i++)
         check_eq($sformatf("wrap d%0d", i), get_rsp(base + i).d,
                  (32'h1c000200 + 32'(4 * i)) ^ 32'hdead0000);

      // grant stall
      idle(2);
      base = rsp_q.size();
      bus.mem_gnt = 1'b0;
      drive(1'b1, 32'h1c000300, 1'b0);
      check_eq("nognt ok",  32'(bus.inst_addr_ok), 32'd0);
      check_eq("nognt req", 32'(bus.mem_req),      32'd1);
      drive(1'b1, 32'h1c000300, 1'b0);
      check_eq("nognt ok2", 32'(bus.inst_addr_ok), 32'd0);
      drive(1'b1, 32'h1c000300, 1'b0);
      bus.mem_gnt = 1'b1;
      #1;
      check_eq("gnt ok", 32'(bus.inst_addr_ok), 32'd1);
      idle(15);
      check_eq("gnt count", 32'(rsp_q.size() - base), 32'd1);
      check_eq("gnt data",  get_rsp(base).d,          32'hc2ad0300);

      // asynchronous reset with reads outstanding
      mem_lat = 5;
      drive(1'b1, 32'h1c000400, 1'b0);
      drive(1'b1, 32'h1c000404, 1'b0);
      drive(1'b1, 32'h1c000408, 1'b0);
      resetn = 1'b0;
      #1;
      check_eq("arst addr_ok", 32'(bus.inst_addr_ok), 32'd0);
      check_eq("arst mem_req", 32'(bus.mem_req),      32'd0);
      check_eq("arst mem_addr", bus.mem_addr,         32'h0);
      check_eq("arst valid",   32'(bus.inst_valid_f), 32'd0);
      idle(2);
      resetn = 1'b1;
      idle(1);
      base = rsp_q.size();
      mem_lat = 2;
      drive(1'b1, 32'h1c000400, 1'b0);
      check_eq("post rst ok", 32'(bus.inst_addr_ok), 32'd1);
      idle(15);
      check_eq("post rst count", 32'(rsp_q.size() - base), 32'd1);
      check_eq("post rst data",  get_rsp(base).d,          32'hc2ad0400);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
